// File: rtl/matrix_scroller_if.sv
// rtl/matrix_scroller_if.sv - message, font-stage and matrix-pin bundle for matrix_scroller
// master is the scroller side; slave is the message store, font stage and matrix.
interface matrix_scroller_if;
  logic       en;
  logic [5:0] msg_len;
  logic [5:0] code_in;
  logic [4:0] char_idx;
  logic [5:0] char_data;
  logic [7:0] col0;
  logic [7:0] col1;
  logic [7:0] col2;
  logic [7:0] col3;
  logic [7:0] col4;
  logic [7:0] col5;
  logic [7:0] col6;
  logic [7:0] row;
  logic [7:0] col_sel;
  logic       frame_done;

  modport master (
    input  en, msg_len, code_in, col0, col1, col2, col3, col4, col5, col6,
    output char_idx, char_data, row, col_sel, frame_done
  );

  modport slave (
    output en, msg_len, code_in, col0, col1, col2, col3, col4, col5, col6,
    input  char_idx, char_data, row, col_sel, frame_done
  );
endinterface

// File: rtl/matrix_scroller.sv
// rtl/matrix_scroller.sv - scrolling marquee driver for an 8x8 LED dot matrix
// Fetches glyphs from the font stage, scrolls them through an 8-column window, and scans it.
module matrix_scroller #(
  parameter int SCAN_DIV   = 1000,
  parameter int SCROLL_DIV = 50
) (
  input logic               clk,
  input logic               rst,
  matrix_scroller_if.master bus
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SCROLL_DIV - 1);
  localparam logic [5:0]         SPACE      = 6'b11_1110;

  logic [1:0]         state;
  logic [4:0]         char_idx;
  logic [5:0]         char_data;
  logic [7:0]         disp [8];
  logic [7:0]         src [7];
  logic [2:0]         src_ptr;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         scan_col;
  logic [FRAME_W-1:0] frame_cnt;
  logic [7:0]         row;
  logic [7:0]         col_sel;
  logic               frame_done;

  logic       scan_tick;
  logic       frame_wrap;
  logic       step_req;
  logic       step;
  logic       last_col;
  logic [5:0] idx_inc;

  assign scan_tick  = (scan_cnt == SCAN_LAST);
  assign frame_wrap = scan_tick && (scan_col == 3'd7);
  assign step_req   = frame_wrap && (frame_cnt == FRAME_LAST) && bus.en;
  assign step       = step_req && (state == S_RUN);
  assign last_col   = (src_ptr == 3'd6);
  // 6-bit compare so an index left stale by a shrinking msg_len still wraps to 0.
  assign idx_inc    = {1'b0, char_idx} + 6'd1;

  assign bus.char_idx   = char_idx;
  assign bus.char_data  = char_data;
  assign bus.row        = row;
  assign bus.col_sel    = col_sel;
  assign bus.frame_done = frame_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      scan_col  <= 3'd0;
      frame_cnt <= '0;
    end else begin
      if (scan_tick) begin
        scan_cnt <= '0;
        scan_col <= scan_col + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      if (frame_wrap) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_REQ;
      char_idx  <= 5'd0;
      char_data <= SPACE;
      src_ptr   <= 3'd0;
      for (int i = 0; i < 7; i++) src[i] <= 8'h00;
    end else begin
      case (state)
        S_REQ: begin
          char_data <= (bus.msg_len == 6'd0) ? SPACE : bus.code_in;
          state     <= S_WAIT;
        end
        S_WAIT: state <= S_LOAD;
        S_LOAD: begin
          src[0]  <= bus.col0;
          src[1]  <= bus.col1;
          src[2]  <= bus.col2;
          src[3]  <= bus.col3;
          src[4]  <= bus.col4;
          src[5]  <= bus.col5;
          src[6]  <= bus.col6;
          src_ptr <= 3'd0;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (step) begin
            if (last_col) begin
              src_ptr  <= 3'd0;
              char_idx <= (idx_inc >= bus.msg_len) ? 5'd0 : idx_inc[4:0];
              state    <= S_REQ;
            end else begin
              src_ptr <= src_ptr + 3'd1;
            end
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) disp[i] <= 8'h00;
    end else if (step) begin
      for (int i = 0; i < 7; i++) disp[i] <= disp[i+1];
      disp[7] <= src[src_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row        <= 8'h00;
      col_sel    <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      row        <= disp[scan_col];
      col_sel    <= ~(8'h01 << scan_col);
      frame_done <= frame_wrap;
    end
  end

  // The fetch takes 3 clks and steps are at least 8 clks apart, so a step never lands outside RUN.
  a_step_in_run: assert property (@(posedge clk) disable iff (!rst) step_req |-> state == S_RUN);
endmodule
